// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the icache (reads) and the dcache (reads/writes).
// Latency: one IDLE arbitration cycle, then the grant cycle; each BUSY cycle adds one.
// Backpressure: the non-granted side sees wait=1; the grant is held through FREE/BUSY/ERROR.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter logic [31:0] BAD          = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        RST,
    // icache side
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    // dcache side
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    // RAM side
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    // status
    output logic        mem_err
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    // Counter wide enough to hold STARVE_LIMIT itself (it saturates there).
    localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] starve_q;
    logic          mem_err_q;

    logic d_req;
    logic starving;
    logic pick_d;
    logic ram_access;
    logic ram_error;

    // Arbitration terms: data wins unless the icache has waited out the bound.
    always_comb begin
        d_req      = dREN | dWEN;
        starving   = iREN && (starve_q == STARVE_MAX);
        pick_d     = d_req && !starving;
        ram_access = (ramstate == RAM_ACCESS);
        ram_error  = (ramstate == RAM_ERROR);
    end

    // State, starvation counter and sticky error; a withdrawn request ends the grant silently.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            mem_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_d) begin
                        state_q <= DGRANT;
                        if (!iREN) begin
                            starve_q <= '0;
                        end else if (starve_q != STARVE_MAX) begin
                            starve_q <= starve_q + CW'(1);
                        end
                    end else if (iREN) begin
                        state_q  <= IGRANT;
                        starve_q <= '0;
                    end else begin
                        starve_q <= '0;
                    end
                end
                IGRANT: begin
                    if (!iREN || ram_access) begin
                        state_q <= IDLE;
                    end else if (ram_error) begin
                        mem_err_q <= 1'b1;
                    end
                end
                DGRANT: begin
                    if (!d_req || ram_access) begin
                        state_q <= IDLE;
                    end else if (ram_error) begin
                        mem_err_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // RAM drive and completion handshakes; enables never depend on ramload or ramstate.
    always_comb begin
        iwait    = 1'b1;
        iload    = BAD;
        dwait    = 1'b1;
        dload    = BAD;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state_q)
            IGRANT: begin
                if (iREN) begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ram_access) begin
                        iwait = 1'b0;
                        iload = ramload;
                    end
                end
            end
            DGRANT: begin
                if (d_req) begin
                    ramaddr = daddr;
                    if (dWEN) begin
                        ramWEN   = 1'b1;
                        ramstore = dstore;
                    end else begin
                        ramREN = 1'b1;
                    end
                    if (ram_access) begin
                        dwait = 1'b0;
                        dload = ramload;
                    end
                end
            end
            default: ;
        endcase
    end

    assign mem_err = mem_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam logic [31:0] B  = 32'hBAD1BAD1;
    localparam logic [1:0]  FR = 2'd0;
    localparam logic [1:0]  BS = 2'd1;
    localparam logic [1:0]  AC = 2'd2;
    localparam logic [1:0]  ER = 2'd3;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, mem_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int n_vec = 0;
    int n_bad = 0;

    mem_arbiter #(.STARVE_LIMIT(4), .BAD(32'hBAD1BAD1)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst, iren;
        logic [31:0] iaddr;
        logic        dren, dwen;
        logic [31:0] daddr, dstore, rload;
        logic [1:0]  rs;
        logic        e_iwait;
        logic [31:0] e_iload;
        logic        e_dwait;
        logic [31:0] e_dload;
        logic        e_ren, e_wen;
        logic [31:0] e_addr, e_store;
        logic        e_err;
    } vec_t;

    function automatic vec_t v(
        input logic rst, input logic iren, input logic [31:0] ia,
        input logic dren, input logic dwen, input logic [31:0] da, input logic [31:0] ds,
        input logic [31:0] rl, input logic [1:0] rs,
        input logic eiw, input logic [31:0] eil, input logic edw, input logic [31:0] edl,
        input logic er, input logic ew, input logic [31:0] ea, input logic [31:0] es,
        input logic ee);
        vec_t t;
        t.rst = rst; t.iren = iren; t.iaddr = ia; t.dren = dren; t.dwen = dwen;
        t.daddr = da; t.dstore = ds; t.rload = rl; t.rs = rs;
        t.e_iwait = eiw; t.e_iload = eil; t.e_dwait = edw; t.e_dload = edl;
        t.e_ren = er; t.e_wen = ew; t.e_addr = ea; t.e_store = es; t.e_err = ee;
        return t;
    endfunction

    // One cycle: drive after the falling edge, compare 1 time unit later.
    task automatic apply_check(input string nm, input vec_t t);
        @(negedge CLK);
        RST = t.rst; iREN = t.iren; iaddr = t.iaddr; dREN = t.dren; dWEN = t.dwen;
        daddr = t.daddr; dstore = t.dstore; ramload = t.rload; ramstate = t.rs;
        #1;
        n_vec++;
        if (iwait !== t.e_iwait || iload !== t.e_iload || dwait !== t.e_dwait ||
            dload !== t.e_dload || ramREN !== t.e_ren || ramWEN !== t.e_wen ||
            ramaddr !== t.e_addr || ramstore !== t.e_store || mem_err !== t.e_err) begin
            n_bad++;
            $display("FAIL %s: got iw=%b il=%h dw=%b dl=%h ren=%b wen=%b a=%h s=%h err=%b, want iw=%b il=%h dw=%b dl=%h ren=%b wen=%b a=%h s=%h err=%b",
                     nm, iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err,
                     t.e_iwait, t.e_iload, t.e_dwait, t.e_dload, t.e_ren, t.e_wen,
                     t.e_addr, t.e_store, t.e_err);
        end
    endtask

    vec_t vecs[$];

    initial begin
        // rst iren iaddr  dren dwen daddr dstore rload rs | iw il dw dl ren wen addr store err
        // reset and idle
        vecs.push_back(v(1,0,0,0,0,0,0,0,FR, 1,B,1,B,0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,FR, 1,B,1,B,0,0,0,0,0));
        // single ifetch
        vecs.push_back(v(0,1,32'h40,0,0,0,0,0,FR, 1,B,1,B,0,0,0,0,0));
        vecs.push_back(v(0,1,32'h40,0,0,0,0,32'h8C220004,AC, 0,32'h8C220004,1,B,1,0,32'h40,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,FR, 1,B,1,B,0,0,0,0,0));
        // simultaneous: dcache write first, then icache read
        vecs.push_back(v(0,1,32'h100,0,1,32'h2000,32'hDEADBEEF,0,FR, 1,B,1,B,0,0,0,0,0));
        vecs.push_back(v(0,1,32'h100,0,1,32'h2000,32'hDEADBEEF,B,AC, 1,B,0,B,0,1,32'h2000,32'hDEADBEEF,0));
        vecs.push_back(v(0,1,32'h100,0,0,0,0,0,FR, 1,B,1,B,0,0,0,0,0));
        vecs.push_back(v(0,1,32'h100,0,0,0,0,32'hCAFEF00D,AC, 0,32'hCAFEF00D,1,B,1,0,32'h100,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,FR, 1,B,1,B,0,0,0,0,0));
        // dREN and dWEN together: write wins
        vecs.push_back(v(0,0,0,1,1,32'h900,32'h13572468,0,FR, 1,B,1,B,0,0,0,0,0));
        vecs.push_back(v(0,0,0,1,1,32'h900,32'h13572468,B,AC, 1,B,0,B,0,1,32'h900,32'h13572468,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,FR, 1,B,1,B,0,0,0,0,0));
        // BUSY x3 then ACCESS on a dcache read
        vecs.push_back(v(0,0,0,1,0,32'h300,0,0,FR, 1,B,1,B,0,0,0,0,0));
        vecs.push_back(v(0,0,0,1,0,32'h300,0,0,BS, 1,B,1,B,1,0,32'h300,0,0));
        vecs.push_back(v(0,0,0,1,0,32'h300,0,0,BS, 1,B,1,B,1,0,32'h300,0,0));
        vecs.push_back(v(0,0,0,1,0,32'h300,0,0,BS, 1,B,1,B,1,0,32'h300,0,0));
        vecs.push_back(v(0,0,0,1,0,32'h300,0,32'h12345678,AC, 1,B,0,32'h12345678,1,0,32'h300,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,FR, 1,B,1,B,0,0,0,0,0));
        // withdrawal during BUSY; next cycle must be IDLE even with ACCESS shown
        vecs.push_back(v(0,0,0,1,0,32'h400,0,0,FR, 1,B,1,B,0,0,0,0,0));
        vecs.push_back(v(0,0,0,1,0,32'h400,0,0,BS, 1,B,1,B,1,0,32'h400,0,0));
        vecs.push_back(v(0,0,0,0,0,32'h400,0,0,BS, 1,B,1,B,0,0,0,0,0));
        vecs.push_back(v(0,0,0,1,0,32'h400,0,32'h55AA55AA,AC, 1,B,1,B,0,0,0,0,0));
        vecs.push_back(v(0,0,0,1,0,32'h400,0,32'h55AA55AA,AC, 1,B,0,32'h55AA55AA,1,0,32'h400,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,FR, 1,B,1,B,0,0,0,0,0));
        // ERROR during IGRANT, retried to ACCESS; mem_err sticks
        vecs.push_back(v(0,1,32'h80,0,0,0,0,0,FR, 1,B,1,B,0,0,0,0,0));
        vecs.push_back(v(0,1,32'h80,0,0,0,0,32'hFFFFFFFF,ER, 1,B,1,B,1,0,32'h80,0,0));
        vecs.push_back(v(0,1,32'h80,0,0,0,0,32'h0F0F0F0F,AC, 0,32'h0F0F0F0F,1,B,1,0,32'h80,0,1));
        vecs.push_back(v(0,0,0,0,0,0,0,0,FR, 1,B,1,B,0,0,0,0,1));
        // reset mid-DGRANT: grant abandoned, no completion, mem_err cleared
        vecs.push_back(v(0,0,0,1,0,32'h500,0,0,FR, 1,B,1,B,0,0,0,0,1));
        vecs.push_back(v(0,0,0,1,0,32'h500,0,0,BS, 1,B,1,B,1,0,32'h500,0,1));
        vecs.push_back(v(1,0,0,1,0,32'h500,0,0,BS, 1,B,1,B,1,0,32'h500,0,1));
        vecs.push_back(v(0,0,0,1,0,32'h500,0,32'h99999999,AC, 1,B,1,B,0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,FR, 1,B,1,B,0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,FR, 1,B,1,B,0,0,0,0,0));

        RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0;
        dstore = 0; ramload = 0; ramstate = FR;
        @(posedge CLK);

        foreach (vecs[i]) begin
            apply_check($sformatf("vec[%0d]", i), vecs[i]);
        end

        // Starvation: both sides request continuously, RAM always ACCESS.
        // Expected grant order with a limit of 4: D D D D I D.
        for (int k = 0; k < 12; k++) begin
            vec_t t;
            logic [31:0] rl;
            int g;
            rl = 32'hA5A50000 + 32'(k);
            g  = k / 2;
            if (k % 2 == 0) begin
                t = v(0,1,32'h700,1,0,32'h600,0,rl,AC, 1,B,1,B,0,0,0,0,0);
            end else if (g == 4) begin
                t = v(0,1,32'h700,1,0,32'h600,0,rl,AC, 0,rl,1,B,1,0,32'h700,0,0);
            end else begin
                t = v(0,1,32'h700,1,0,32'h600,0,rl,AC, 1,B,0,rl,1,0,32'h600,0,0);
            end
            apply_check($sformatf("starve[%0d]", k), t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port memory arbiter directly downstream of the instruction cache and the data cache.
- Consumes icache read requests (iREN/iaddr) and dcache read/write requests (dREN/dWEN/daddr/dstore).
- Grants exactly one requester at a time to the RAM and returns iwait/iload and dwait/dload.
- Data side has priority, with a starvation bound that guarantees instruction fetch progress.

Parameters:
- STARVE_LIMIT, 4: consecutive dcache grants allowed while iREN is pending before the icache is forced to win.
- BAD, 32'hBAD1BAD1: value driven on iload/dload when the corresponding side is not being served.

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- iREN  in  1  icache read request
- iaddr  in  32  icache word address
- iwait  out  1  0 only in the cycle the icache read completes
- iload  out  32  read data, valid when iwait=0
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  32  dcache address
- dstore  in  32  dcache write data
- dwait  out  1  0 only in the cycle the dcache access completes
- dload  out  32  read data, valid when dwait=0 on a read
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- mem_err  out  1  sticky error flag

Behaviour:
- Reset (RST=1 at an edge):
  - state=IDLE, starve counter=0, mem_err=0.
  - Outputs combinationally: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=dload=BAD.
  - Reset mid-transfer abandons the grant with no completion pulse.
- States:
  - IDLE: no RAM enables. Next state is chosen from the requests present this cycle.
    - dREN|dWEN and not starving -> DGRANT.
    - else iREN -> IGRANT.
    - else IDLE.
    - Starving means iREN=1 and counter==STARVE_LIMIT; starving forces IGRANT even if the data side is requesting.
  - IGRANT:
    - ramREN=1, ramaddr=iaddr.
    - When ramstate==ACCESS: iwait=0, iload=ramload, next IDLE.
  - DGRANT:
    - ramaddr=daddr.
    - If dWEN: ramWEN=1, ramstore=dstore, ramREN=0. dWEN has priority if dREN and dWEN are both high.
    - Else ramREN=1.
    - When ramstate==ACCESS: dwait=0, dload=ramload (reads), next IDLE.
- Latency: minimum request-to-completion is 2 cycles (IDLE arbitration cycle, then grant cycle with ACCESS). Each extra BUSY cycle adds 1. Back-to-back completions to the same requester are separated by at least one IDLE cycle.
- Grant holding: the grant is held while ramstate is FREE or BUSY. There is no preemption.
- Request withdrawn mid-grant (the granted side's enable drops): enables drop the same cycle (combinational), no completion, next IDLE.
- ramstate==ERROR: no completion, grant held, retried the next cycle. mem_err is set at the edge and held until reset.
- Starve counter, updated on the IDLE-to-grant transition:
  - DGRANT while iREN=1: counter increments, saturating at STARVE_LIMIT.
  - IGRANT, or iREN=0 in IDLE: counter clears to 0.
- The non-granted side always sees wait=1 and load=BAD.
- No combinational path from ramload to any enable.

Test Plan:
- Reset then idle: RST=1 for 2 cycles -> iwait=dwait=1, ramREN=ramWEN=0, iload=dload=32'hBAD1BAD1, mem_err=0.
- Single ifetch: iREN=1, iaddr=0x40, RAM model returns ACCESS on the first grant cycle with ramload=0x8C220004 -> completion in cycle 2, iwait=0 for exactly 1 cycle, iload=0x8C220004, ramaddr=0x40.
- Simultaneous requests: iREN=1 (0x100) and dWEN=1 (daddr 0x2000, dstore 0xDEADBEEF) -> write served first: ramWEN=1, ramstore=0xDEADBEEF, dwait pulses. After one IDLE cycle, the icache read is served.
- Starvation: dREN held high continuously, iREN=1, RAM always ACCESS, STARVE_LIMIT=4 -> 4 dcache completions, then an icache completion on the 5th grant, then the counter clears and the dcache resumes.
- BUSY stretch and withdrawal: ramstate BUSY 3 cycles then ACCESS -> dwait=0 only on the ACCESS cycle. Separately, drop dREN during BUSY -> ramREN falls the same cycle, no dwait pulse, state IDLE next.
- Error and reset: ramstate=ERROR for 1 cycle during IGRANT, then ACCESS -> mem_err=1, iwait=0 on the later ACCESS cycle. Then assert RST mid-DGRANT -> all enables 0 the next cycle, mem_err=0.
